// File: rtl/sha1_msg_feeder.sv
// sha1_msg_feeder: packs a 32-bit word stream into padded 512-bit SHA-1 blocks and drives the core handshake; define SHA1_FEEDER_BSWAP_EN to byte-swap input words
module sha1_msg_feeder #(
  parameter int LEN_W = 64
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [31:0]  s_data,
  input  logic         s_valid,
  input  logic         s_last,
  input  logic [2:0]   s_bytes,
  output logic         s_ready,
  output logic         core_init,
  output logic         core_next,
  output logic [511:0] core_block,
  input  logic         core_ready,
  input  logic [159:0] core_digest,
  input  logic         core_digest_valid,
  output logic [159:0] digest,
  output logic         digest_valid,
  output logic         busy
);
  typedef enum logic [2:0] {COLLECT, PAD, LEN, ISSUE, WAIT, FINISH} state_t;
  state_t             r_state;
  logic [15:0][31:0]  r_blk;
  logic [4:0]         r_idx;
  logic [LEN_W-1:0]   r_len;
  logic               r_first;
  logic               r_final;
  logic               r_pad_pending;
  logic               r_mark_pending;
  logic [159:0]       r_digest;
  logic               r_digest_valid;
  logic [31:0]        w_word;
  logic [4:0]         w_shift;
  logic [31:0]        w_tail;
  logic               w_full;
  logic               w_pulse;
  logic [63:0]        w_len64;
  logic [3:0]         w_slot;
`ifdef SHA1_FEEDER_BSWAP_EN
  assign w_word = {s_data[7:0], s_data[15:8], s_data[23:16], s_data[31:24]};
`else
  assign w_word = s_data;
`endif
  assign w_shift = {s_bytes[1:0], 3'b000};
  assign w_tail = (w_word & ~(32'hffff_ffff >> w_shift)) | (32'h8000_0000 >> w_shift);
  assign w_full = s_bytes[2];
  assign w_pulse = (r_state == ISSUE) & core_ready;
  assign w_len64 = 64'(r_len);
  assign w_slot = 4'd15 - r_idx[3:0];
  assign s_ready = r_state == COLLECT;
  assign core_init = w_pulse & r_first;
  assign core_next = w_pulse & ~r_first;
  assign core_block = r_blk;
  assign digest = r_digest;
  assign digest_valid = r_digest_valid;
  assign busy = (r_state != COLLECT) | (r_idx != 5'd0);
  // block assembly, padding and core handshake sequencing
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= COLLECT;
      r_blk <= '0;
      r_idx <= '0;
      r_len <= '0;
      r_first <= 1'b1;
      r_final <= 1'b0;
      r_pad_pending <= 1'b0;
      r_mark_pending <= 1'b0;
      r_digest <= '0;
      r_digest_valid <= 1'b0;
    end else begin
      r_digest_valid <= 1'b0;
      case (r_state)
        COLLECT: if (s_valid) begin
          r_blk[w_slot] <= (s_last & ~w_full) ? w_tail : w_word;
          r_idx <= r_idx + 5'd1;
          r_len <= r_len + LEN_W'({s_bytes, 3'b000});
          if (s_last) begin
            r_mark_pending <= w_full;
            r_state <= PAD;
          end else if (r_idx == 5'd15) begin
            r_pad_pending <= 1'b0;
            r_state <= ISSUE;
          end
        end
        PAD: if (r_idx[4]) begin
          r_pad_pending <= 1'b1;
          r_state <= ISSUE;
        end else if (!r_mark_pending && r_idx == 5'd14) begin
          r_state <= LEN;
        end else begin
          r_blk[w_slot] <= r_mark_pending ? 32'h8000_0000 : 32'h0;
          r_mark_pending <= 1'b0;
          r_idx <= r_idx + 5'd1;
        end
        LEN: begin
          r_blk[1] <= w_len64[63:32];
          r_blk[0] <= w_len64[31:0];
          r_pad_pending <= 1'b0;
          r_final <= 1'b1;
          r_state <= ISSUE;
        end
        ISSUE: if (core_ready) begin
          r_first <= 1'b0;
          r_idx <= '0;
          r_state <= WAIT;
        end
        WAIT: if (core_ready & core_digest_valid)
          r_state <= r_final ? FINISH : r_pad_pending ? PAD : COLLECT;
        FINISH: begin
          r_digest <= core_digest;
          r_digest_valid <= 1'b1;
          r_len <= '0;
          r_first <= 1'b1;
          r_final <= 1'b0;
          r_state <= COLLECT;
        end
        default: r_state <= COLLECT;
      endcase
    end
  end
endmodule

// File: tb/tb_sha1_msg_feeder.sv
// tb_sha1_msg_feeder: table-driven messages against a behavioural SHA-1 core with block and digest scoreboards
`timescale 1ns/1ps
module tb_sha1_msg_feeder;
  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [31:0]  s_data = '0;
  logic         s_valid = 1'b0;
  logic         s_last = 1'b0;
  logic [2:0]   s_bytes = '0;
  logic         s_ready;
  logic         core_init;
  logic         core_next;
  logic [511:0] core_block;
  logic         core_ready;
  logic [159:0] core_digest;
  logic         core_digest_valid;
  logic [159:0] digest;
  logic         digest_valid;
  logic         busy;
  always #5 clk = ~clk;
  sha1_msg_feeder dut (
    .clk(clk), .reset_n(reset_n), .s_data(s_data), .s_valid(s_valid), .s_last(s_last),
    .s_bytes(s_bytes), .s_ready(s_ready), .core_init(core_init), .core_next(core_next),
    .core_block(core_block), .core_ready(core_ready), .core_digest(core_digest),
    .core_digest_valid(core_digest_valid), .digest(digest), .digest_valid(digest_valid), .busy(busy)
  );
  localparam logic [159:0] IV = 160'h67452301_efcdab89_98badcfe_10325476_c3d2e1f0;
  localparam logic [159:0] D_ABC = 160'ha9993e36_4706816a_ba3e2571_7850c26c_9cd0d89d;
  localparam logic [159:0] D_EMPTY = 160'hda39a3ee_5e6b4b0d_3255bfef_95601890_afd80709;
  localparam logic [159:0] D_56 = 160'h84983e44_1c3bd26e_baae4aa1_f95129e5_e54670f1;
  localparam logic [511:0] ABC_BLK = {32'h61626380, 416'h0, 64'h18};
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic logic [31:0] rol(input logic [31:0] x, input int s);
    return (x << s) | (x >> (32 - s));
  endfunction
  function automatic logic [159:0] compress(input logic [159:0] h, input logic [511:0] b);
    logic [31:0] w[80];
    logic [31:0] a, bb, c, d, e, f, k, t;
    for (int i = 0; i < 16; i++) w[i] = b[511-32*i -: 32];
    for (int i = 16; i < 80; i++) w[i] = rol(w[i-3] ^ w[i-8] ^ w[i-14] ^ w[i-16], 1);
    {a, bb, c, d, e} = h;
    for (int i = 0; i < 80; i++) begin
      if (i < 20) begin f = (bb & c) | (~bb & d); k = 32'h5a827999; end
      else if (i < 40) begin f = bb ^ c ^ d; k = 32'h6ed9eba1; end
      else if (i < 60) begin f = (bb & c) | (bb & d) | (c & d); k = 32'h8f1bbcdc; end
      else begin f = bb ^ c ^ d; k = 32'hca62c1d6; end
      t = rol(a, 5) + f + e + k + w[i];
      e = d; d = c; c = rol(bb, 30); bb = a; a = t;
    end
    return {h[159:128] + a, h[127:96] + bb, h[95:64] + c, h[63:32] + d, h[31:0] + e};
  endfunction
  // behavioural core: samples the handshake mid-cycle, reacts on the next rising edge
  logic         stall = 1'b0;
  logic         smp_init = 1'b0;
  logic         smp_next = 1'b0;
  logic [511:0] smp_blk = '0;
  logic         c_rdy, c_dv;
  logic [159:0] c_dig, c_h;
  int           c_cnt;
  assign core_ready = c_rdy & ~stall;
  assign core_digest_valid = c_dv;
  assign core_digest = c_dig;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_rdy <= 1'b1; c_dv <= 1'b0; c_dig <= '0; c_h <= '0; c_cnt <= 0;
    end else if (smp_init | smp_next) begin
      c_h <= compress(smp_init ? IV : c_h, smp_blk);
      c_rdy <= 1'b0; c_dv <= 1'b0; c_cnt <= int'($urandom_range(3, 10));
    end else if (!c_rdy) begin
      if (c_cnt == 0) begin c_rdy <= 1'b1; c_dv <= 1'b1; c_dig <= c_h; end
      else c_cnt <= c_cnt - 1;
    end
  end
  // scoreboards: expected blocks/pulse kinds at each core pulse, expected digest at digest_valid
  logic [511:0] exp_blk[$];
  bit           exp_first[$];
  logic [159:0] exp_dig[$];
  int           done_cnt = 0;
  int           pulse_cnt = 0;
  always @(negedge clk) begin
    smp_init = core_init;
    smp_next = core_next;
    smp_blk = core_block;
    if (core_init | core_next) begin
      pulse_cnt++;
      if (exp_blk.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_pulse: got init=%0b next=%0b required none", core_init, core_next);
      end else begin
        chk("pulse_kind", {core_init, core_next}, exp_first.pop_front() ? 2'b10 : 2'b01);
        chk("core_block", core_block, exp_blk.pop_front());
      end
    end
    if (digest_valid) begin
      done_cnt++;
      if (exp_dig.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_digest: got %0h required none", digest);
      end else chk("digest", digest, exp_dig.pop_front());
    end
  end
  logic [7:0] mb[256];
  task automatic expect_msg(input int len, input logic [159:0] known);
    logic [7:0] pb[320];
    logic [63:0] bl;
    logic [511:0] blk;
    logic [159:0] h;
    int nb;
    nb = (len + 8) / 64 + 1;
    bl = 64'(len) * 64'd8;
    for (int i = 0; i < nb * 64; i++)
      pb[i] = i < len ? mb[i] : i == len ? 8'h80 : i >= nb * 64 - 8 ? bl[8*(nb*64-1-i) +: 8] : 8'h00;
    h = IV;
    for (int b = 0; b < nb; b++) begin
      for (int j = 0; j < 64; j++) blk[511-8*j -: 8] = pb[64*b+j];
      exp_blk.push_back(blk);
      exp_first.push_back(b == 0);
      h = compress(h, blk);
    end
    exp_dig.push_back(known != '0 ? known : h);
  endtask
  task automatic send_word(input logic [31:0] d, input logic [2:0] n, input logic l);
    int w;
    w = 0;
    s_data = d; s_bytes = n; s_last = l; s_valid = 1'b1;
    while (!s_ready && w < 2000) begin @(negedge clk); w++; end
    chk("s_ready_timeout", 32'(w < 2000), 32'd1);
    @(negedge clk);
    s_valid = 1'b0; s_last = 1'b0; s_data = $urandom;
  endtask
  task automatic send_msg(input int len, input int gap, input bit zt);
    int n;
    logic [31:0] d;
    if (len == 0) send_word($urandom, 3'd0, 1'b1);
    for (int w = 0; w * 4 < len; w++) begin
      n = (len - 4 * w > 4) ? 4 : len - 4 * w;
      d = $urandom;
      for (int k = 0; k < n; k++)
`ifdef SHA1_FEEDER_BSWAP_EN
        d[8*k +: 8] = mb[4*w+k];
`else
        d[31-8*k -: 8] = mb[4*w+k];
`endif
      send_word(d, 3'(n), (4 * w + n == len) && !zt);
      repeat (gap > 0 ? $urandom_range(0, gap) : 0) @(negedge clk);
    end
    if (zt) send_word($urandom, 3'd0, 1'b1);
  endtask
  task automatic wait_done(input int target);
    int w;
    w = 0;
    while (done_cnt < target && w < 3000) begin @(negedge clk); w++; end
    chk("digest_arrived", 32'(done_cnt >= target), 32'd1);
  endtask
  task automatic load(input string txt, input int len);
    for (int k = 0; k < len; k++) mb[k] = txt.len() > 0 ? txt[k] : 8'(k * 37 + 11);
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_flags"}, {s_ready, core_init, core_next, digest_valid, busy}, 5'b10000);
    chk({tag, "_block"}, core_block, '0);
    chk({tag, "_digest"}, digest, '0);
  endtask
  typedef struct {
    string        txt;
    int           len;
    int           gap;
    bit           zt;
    logic [159:0] known;
  } vec_t;
  vec_t tv[$];
  initial begin
    int t, bad, w;
    tv.push_back('{"abc", 3, 0, 1'b0, D_ABC});
    tv.push_back('{"", 0, 0, 1'b0, D_EMPTY});
    tv.push_back('{"abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq", 56, 0, 1'b0, D_56});
    tv.push_back('{"abc", 3, 4, 1'b0, D_ABC});
    tv.push_back('{"", 55, 0, 1'b0, '0});
    tv.push_back('{"", 52, 0, 1'b0, '0});
    tv.push_back('{"", 53, 1, 1'b0, '0});
    tv.push_back('{"", 60, 0, 1'b0, '0});
    tv.push_back('{"", 61, 0, 1'b0, '0});
    tv.push_back('{"", 63, 2, 1'b0, '0});
    tv.push_back('{"", 4, 0, 1'b1, '0});
    tv.push_back('{"", 64, 0, 1'b1, '0});
    tv.push_back('{"", 100, 3, 1'b0, '0});
    tv.push_back('{"", 130, 0, 1'b0, '0});
    repeat (3) @(negedge clk);
    check_reset("reset");
    reset_n = 1'b1;
    @(negedge clk);
    foreach (tv[i]) begin
      load(tv[i].txt, tv[i].len);
      expect_msg(tv[i].len, tv[i].known);
      t = done_cnt + 1;
      send_msg(tv[i].len, tv[i].gap, tv[i].zt);
      wait_done(t);
    end
    // 64-byte message: input stays blocked from the first issue until the digest appears
    load("", 64);
    expect_msg(64, '0);
    t = done_cnt + 1;
    send_msg(64, 0, 1'b0);
    bad = 0; w = 0;
    while (done_cnt < t && w < 3000) begin
      if (s_ready && !digest_valid) bad++;
      @(negedge clk); w++;
    end
    chk("s_ready_low_64", 32'(bad), 32'd0);
    chk("digest_64_arrived", 32'(done_cnt >= t), 32'd1);
    // core busy for 20 cycles while a block waits in ISSUE
    stall = 1'b1;
    load("abc", 3);
    expect_msg(3, D_ABC);
    t = done_cnt + 1;
    send_msg(3, 2, 1'b0);
    repeat (30) @(negedge clk);
    for (int c = 0; c < 20; c++) begin
      chk("stall_no_pulse", {core_init, core_next}, 2'b00);
      chk("stall_block", core_block, ABC_BLK);
      @(negedge clk);
    end
    stall = 1'b0;
    wait_done(t);
    // reset while the core is processing
    load("abc", 3);
    expect_msg(3, D_ABC);
    t = pulse_cnt + 1;
    send_msg(3, 0, 1'b0);
    w = 0;
    while (pulse_cnt < t && w < 100) begin @(negedge clk); w++; end
    chk("pulse_before_reset", 32'(pulse_cnt >= t), 32'd1);
    @(negedge clk);
    reset_n = 1'b0;
    exp_blk.delete(); exp_first.delete(); exp_dig.delete();
    @(negedge clk);
    check_reset("midreset");
    reset_n = 1'b1;
    @(negedge clk);
    load("abc", 3);
    expect_msg(3, D_ABC);
    t = done_cnt + 1;
    send_msg(3, 0, 1'b0);
    wait_done(t);
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 32'(exp_dig.size() + exp_blk.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
endmodule
